mips_cpu: RTL and testbench
===========================

MIPS_CPU -- requirements
Module: mips_cpu

Interface
REQ-001 Ports: clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 Ports: rst  input  1  reset, synchronous and active-high.
REQ-003 No other top-level ports; the bench observes state hierarchically only.
REQ-004 Hierarchy SHALL be fixed for bench probing:
- datapath_1.gpr_1.rgs[0:31] (32x32 register file)
- datapath_1.alu_1.zero, .positive, .overflow (1-bit ALU flags)
- datapath_1.ifu_1.pc (32-bit program counter)
- datapath_1.ifu_1.i1.im (instruction memory array)
REQ-005 Parameters: none.

Function
REQ-006 Single-cycle MIPS core: each instruction fetched, executed and committed in one clk cycle; CPI = 1.
REQ-007 Instruction memory: 1024 x 32-bit words, read combinationally, word index = pc[11:2]; im[0] is the word at the reset PC.
- Loaded by the bench with hex words.
- Not writable by the core.
REQ-008 Data memory: 1024 x 32-bit words, word index = addr[11:2].
- Combinational read.
- Write on rising clk edge when sw executes.
REQ-009 Supported instructions: addu, subu, slt, jr, addi, addiu, ori, lui, lw, sw, beq, j, jal.
REQ-010 Any other opcode/funct SHALL execute as a NOP: no register/memory write, PC+4.
REQ-011 Arithmetic rules:
- addu/subu/addiu wrap modulo 2^32.
- slt is a signed compare, result 1 or 0.
- ori and lui zero-extend imm; lui writes {imm,16'h0}.
- addi, addiu, lw, sw sign-extend imm.
REQ-012 addi overflow: if the signed add overflows, rt SHALL NOT be written and alu overflow SHALL be 1 that cycle.
REQ-013 ALU flags are combinational on the current ALU result:
- zero = (result == 0)
- positive = result is signed > 0
- overflow = signed-add/sub overflow of the current operation
REQ-014 Register file: 2 combinational read ports, 1 write port on rising clk.
- Writes to register 0 are ignored; rgs[0] always reads 0.
- Write-back destination: rd (R-type), rt (I-type), 31 (jal).
REQ-015 Next PC, default pc+4:
- beq taken: pc+4+(sext(imm)<<2)
- j/jal: {pc_plus4[31:28], target, 2'b00}
- jal writes pc+4 to $31
- jr: rs value
REQ-016 Read-during-write to the same register in one cycle returns the old value; the new value is visible next cycle.

Reset
REQ-017 On a rising clk with rst=1: pc <= 32'h0000_3000 and all 32 registers <= 0.
REQ-018 While rst=1: no data-memory writes, no instruction commits.
REQ-019 Data memory and instruction memory contents are NOT cleared by reset.
REQ-020 First instruction (im[0]) executes on the first rising edge after rst deasserts; reset mid-program aborts the current instruction and restarts from 32'h0000_3000.

Verification
REQ-021 Reset held 1 cycle -> pc = 0x00003000, rgs[1..31] = 0; first post-reset edge -> pc = 0x00003004.
REQ-022 ori $1,$0,0x1234; lui $2,0xABCD; addu $3,$1,$2 -> rgs[1]=0x00001234, rgs[2]=0xABCD0000, rgs[3]=0xABCD1234.
REQ-023 ori $8,$0,8; sw $8,4($0); lw $9,4($0) -> rgs[9]=8; subu $10,$9,$8 -> rgs[10]=0, zero=1 in that cycle.
REQ-024 lui $6,0x7FFF; ori $6,$6,0xFFFF; addi $11,$6,1 -> overflow=1, rgs[11] unchanged (0).
REQ-025 beq $0,$0,+1 at 0x3000 -> next pc = 0x3008; jal to 0x3010 at 0x3008 -> rgs[31]=0x0000300C; jr $31 -> pc = 0x300C.
REQ-026 addu $0,$1,$1 with rgs[1]≠0 -> rgs[0] stays 0.

Source files
------------

// File: rtl/mips_cpu.sv
// Single-cycle MIPS core: fetch, decode, execute and commit in one clk cycle.
// Latency 1 cycle per instruction; no backpressure, the core never stalls.

package mips_pkg;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_OR, ALU_SLT, ALU_LUI} alu_op_e;
    typedef enum logic [1:0] {DST_RD, DST_RT, DST_RA} dst_e;

    typedef struct packed {
        logic    reg_we;
        dst_e    dst;
        alu_op_e alu_op;
        logic    b_imm;
        logic    sext;
        logic    mem_we;
        logic    mem_to_reg;
        logic    link;
        logic    branch;
        logic    jump;
        logic    jump_reg;
        logic    ovf_chk;
    } ctrl_t;
endpackage

// Instruction ROM, 1024 words, preloaded externally.
// Combinational read; no backpressure.
// Never written by the core.
module im (
    input  logic [9:0]  addr,
    output logic [31:0] instr
);
    logic [31:0] im [0:1023];
    assign instr = im[addr];
endmodule

// Fetch unit: program counter, next-PC selection and instruction fetch.
// PC updates every rising clk; instruction is available combinationally.
// No backpressure.
module ifu (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [31:0] rs_val,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4
);
    logic [31:0] pc;
    logic [31:0] npc;

    im i1 (.addr(pc[11:2]), .instr(instr));

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        npc = pc_plus4;
        if (jump_reg)
            npc = rs_val;
        else if (jump)
            npc = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (branch_taken)
            npc = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc <= 32'h0000_3000;
        else
            pc <= npc;
    end
endmodule

// 32x32 register file, two combinational read ports, one write port.
// Writes land on the rising edge, so a same-cycle read returns the old value.
// No backpressure; register 0 is hardwired to zero.
module gpr (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] rgs [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                rgs[i] <= '0;
        end else if (we && wa != 5'd0) begin
            rgs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : rgs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : rgs[ra2];
endmodule

// ALU with flags derived from the current result.
// Purely combinational; no backpressure.
// Overflow is meaningful only for add/sub, zero otherwise.
module alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] result,
    output logic        zero,
    output logic        positive,
    output logic        overflow
);
    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            ALU_ADD: begin
                result   = sum;
                overflow = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'd0, ($signed(a) < $signed(b))};
            ALU_LUI: result = {b[15:0], 16'h0000};
            default: result = '0;
        endcase
    end

    assign zero     = (result == 32'd0);
    assign positive = !result[31] && !zero;
endmodule

// Datapath: decode, operand select, ALU, data memory and write-back.
// Every instruction completes in the cycle it is fetched.
// No backpressure; reset suppresses memory writes.
module datapath
    import mips_pkg::*;
(
    input logic clk,
    input logic rst
);
    logic [31:0] instr, pc_plus4, rd1, rd2, imm_ext, alu_b, alu_res, wd;
    logic [4:0]  wa;
    logic        zero, positive, overflow;
    ctrl_t       ctrl;
    logic [31:0] dm [0:1023];

    // R-type encodings with a nonzero shamt are not valid for these functs and fall to NOP.
    always_comb begin
        ctrl = '0;
        case (instr[31:26])
            6'h00: if (instr[10:6] == 5'd0) begin
                case (instr[5:0])
                    6'h21: begin ctrl.reg_we = 1'b1; ctrl.dst = DST_RD; ctrl.alu_op = ALU_ADD; end
                    6'h23: begin ctrl.reg_we = 1'b1; ctrl.dst = DST_RD; ctrl.alu_op = ALU_SUB; end
                    6'h2A: begin ctrl.reg_we = 1'b1; ctrl.dst = DST_RD; ctrl.alu_op = ALU_SLT; end
                    6'h08: ctrl.jump_reg = 1'b1;
                    default: ctrl = '0;
                endcase
            end
            6'h08: begin ctrl.reg_we = 1'b1; ctrl.dst = DST_RT; ctrl.b_imm = 1'b1; ctrl.sext = 1'b1; ctrl.ovf_chk = 1'b1; end
            6'h09: begin ctrl.reg_we = 1'b1; ctrl.dst = DST_RT; ctrl.b_imm = 1'b1; ctrl.sext = 1'b1; end
            6'h0D: begin ctrl.reg_we = 1'b1; ctrl.dst = DST_RT; ctrl.b_imm = 1'b1; ctrl.alu_op = ALU_OR; end
            6'h0F: begin ctrl.reg_we = 1'b1; ctrl.dst = DST_RT; ctrl.b_imm = 1'b1; ctrl.alu_op = ALU_LUI; end
            6'h23: begin ctrl.reg_we = 1'b1; ctrl.dst = DST_RT; ctrl.b_imm = 1'b1; ctrl.sext = 1'b1; ctrl.mem_to_reg = 1'b1; end
            6'h2B: begin ctrl.mem_we = 1'b1; ctrl.b_imm = 1'b1; ctrl.sext = 1'b1; end
            6'h04: begin ctrl.branch = 1'b1; ctrl.alu_op = ALU_SUB; end
            6'h02: ctrl.jump = 1'b1;
            6'h03: begin ctrl.jump = 1'b1; ctrl.link = 1'b1; ctrl.reg_we = 1'b1; ctrl.dst = DST_RA; end
            default: ctrl = '0;
        endcase
    end

    assign imm_ext = ctrl.sext ? {{16{instr[15]}}, instr[15:0]} : {16'h0000, instr[15:0]};
    assign alu_b   = ctrl.b_imm ? imm_ext : rd2;

    always_comb begin
        case (ctrl.dst)
            DST_RT:  wa = instr[20:16];
            DST_RA:  wa = 5'd31;
            default: wa = instr[15:11];
        endcase
    end

    assign wd = ctrl.link       ? pc_plus4 :
                ctrl.mem_to_reg ? dm[alu_res[11:2]] : alu_res;

    ifu ifu_1 (
        .clk          (clk),
        .rst          (rst),
        .branch_taken (ctrl.branch && zero),
        .jump         (ctrl.jump),
        .jump_reg     (ctrl.jump_reg),
        .rs_val       (rd1),
        .instr        (instr),
        .pc_plus4     (pc_plus4)
    );

    gpr gpr_1 (
        .clk (clk),
        .rst (rst),
        .ra1 (instr[25:21]),
        .ra2 (instr[20:16]),
        .wa  (wa),
        .we  (ctrl.reg_we && !(ctrl.ovf_chk && overflow)),
        .wd  (wd),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    alu alu_1 (
        .a        (rd1),
        .b        (alu_b),
        .op       (ctrl.alu_op),
        .result   (alu_res),
        .zero     (zero),
        .positive (positive),
        .overflow (overflow)
    );

    always_ff @(posedge clk) begin
        if (!rst && ctrl.mem_we)
            dm[alu_res[11:2]] <= rd2;
    end
endmodule

// Top level: clock and synchronous reset only; all state lives in the datapath.
// One instruction committed per rising clk.
// No backpressure.
module mips_cpu (
    input logic clk,
    input logic rst
);
    datapath datapath_1 (.clk(clk), .rst(rst));
endmodule

// File: tb/tb_mips_cpu.sv
// Bench for mips_cpu: directed programs, expected architectural state queued per commit count.
module tb_mips_cpu;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mips_cpu dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    typedef enum {K_PC, K_REG, K_ZERO, K_POS, K_OVF} kind_e;
    typedef struct {
        int          phase;
        int          k;
        kind_e       kind;
        logic [4:0]  idx;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    exp_t        left;
    logic [31:0] act;
    int          checks = 0;
    int          errors = 0;
    int          phase  = 1;
    int          k_mon  = -1;

    logic [31:0] prog_a [0:17] = '{
        32'h34011234, 32'h3C02ABCD, 32'h00221821, 32'h34080008,
        32'hAC080004, 32'h8C090004, 32'h01285023, 32'h3C067FFF,
        32'h34C6FFFF, 32'h20CB0001, 32'h00210021, 32'h0041602A,
        32'h0022682A, 32'h240EFFFF, 32'h01CE7821, 32'hFFFFFFFF,
        32'h8C100004, 32'h08000C11};
    logic [31:0] prog_b [0:4] = '{
        32'h10000001, 32'h3414DEAD, 32'h0C000C04, 32'h34150055, 32'h03E00008};

    task automatic push(input int ph, input int k, input kind_e kd, input logic [4:0] idx,
                        input logic [31:0] v, input string nm);
        exp_t e;
        e.phase = ph; e.k = k; e.kind = kd; e.idx = idx; e.exp = v; e.name = nm;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] probe(input kind_e kd, input logic [4:0] idx);
        case (kd)
            K_PC:    return dut.datapath_1.ifu_1.pc;
            K_REG:   return dut.datapath_1.gpr_1.rgs[idx];
            K_ZERO:  return {31'd0, dut.datapath_1.alu_1.zero};
            K_POS:   return {31'd0, dut.datapath_1.alu_1.positive};
            K_OVF:   return {31'd0, dut.datapath_1.alu_1.overflow};
            default: return 32'd0;
        endcase
    endfunction

    // k_mon = instructions committed since the last reset edge.
    always @(posedge clk) begin
        if (rst)
            k_mon <= 0;
        else if (k_mon >= 0)
            k_mon <= k_mon + 1;
    end

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].phase == phase && sb[0].k == k_mon) begin
            cur = sb.pop_front();
            act = probe(cur.kind, cur.idx);
            checks++;
            if (act !== cur.exp) begin
                errors++;
                $display("FAIL %s: actual %h, expected %h", cur.name, act, cur.exp);
            end
        end
    end

    task automatic drain_wait();
        for (int n = 0; n < 200 && sb.size() > 0; n++)
            @(posedge clk);
        while (sb.size() > 0) begin
            left = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never observed within cycle budget, expected %h", left.name, left.exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 18; i++)
            dut.datapath_1.ifu_1.i1.im[i] = prog_a[i];

        push(1, 0,  K_PC,   0, 32'h00003000, "reset_pc");
        push(1, 0,  K_REG,  1, 32'h00000000, "reset_r1");
        push(1, 0,  K_REG, 31, 32'h00000000, "reset_r31");
        push(1, 1,  K_PC,   0, 32'h00003004, "first_commit_pc");
        push(1, 2,  K_POS,  0, 32'd0,        "addu_neg_positive");
        push(1, 2,  K_ZERO, 0, 32'd0,        "addu_neg_zero");
        push(1, 3,  K_REG,  1, 32'h00001234, "ori_r1");
        push(1, 3,  K_REG,  2, 32'hABCD0000, "lui_r2");
        push(1, 3,  K_REG,  3, 32'hABCD1234, "addu_r3");
        push(1, 3,  K_POS,  0, 32'd1,        "ori_positive");
        push(1, 6,  K_REG,  9, 32'h00000008, "sw_lw_r9");
        push(1, 6,  K_ZERO, 0, 32'd1,        "subu_zero");
        push(1, 7,  K_REG, 10, 32'h00000000, "subu_r10");
        push(1, 9,  K_REG,  6, 32'h7FFFFFFF, "lui_ori_r6");
        push(1, 9,  K_OVF,  0, 32'd1,        "addi_overflow");
        push(1, 10, K_REG, 11, 32'h00000000, "addi_ovf_no_write");
        push(1, 10, K_OVF,  0, 32'd0,        "addu_no_overflow");
        push(1, 11, K_REG,  0, 32'h00000000, "r0_write_ignored");
        push(1, 12, K_REG, 12, 32'h00000001, "slt_neg_lt_pos");
        push(1, 13, K_REG, 13, 32'h00000000, "slt_pos_lt_neg");
        push(1, 14, K_REG, 14, 32'hFFFFFFFF, "addiu_sext");
        push(1, 15, K_REG, 15, 32'hFFFFFFFE, "addu_wrap");
        push(1, 16, K_PC,   0, 32'h00003040, "nop_pc");
        push(1, 16, K_REG, 31, 32'h00000000, "nop_no_write");
        push(1, 17, K_REG, 16, 32'h00000008, "lw_again_r16");
        push(1, 20, K_PC,   0, 32'h00003044, "j_self_pc");

        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        drain_wait();

        checks++;
        if (dut.datapath_1.ifu_1.pc !== 32'h00003044) begin
            errors++;
            $display("FAIL end_a_pc: actual %h, expected %h", dut.datapath_1.ifu_1.pc, 32'h00003044);
        end
        checks++;
        if (dut.datapath_1.gpr_1.rgs[3] !== 32'hABCD1234) begin
            errors++;
            $display("FAIL end_a_r3: actual %h, expected %h", dut.datapath_1.gpr_1.rgs[3], 32'hABCD1234);
        end
        checks++;
        if (dut.datapath_1.gpr_1.rgs[0] !== 32'h00000000) begin
            errors++;
            $display("FAIL end_a_r0: actual %h, expected %h", dut.datapath_1.gpr_1.rgs[0], 32'h00000000);
        end

        // Mid-program reset: swap in the branch/jump program while reset is held.
        @(posedge clk);
        #2 rst = 1'b1;
        phase = 2;
        for (int i = 0; i < 5; i++)
            dut.datapath_1.ifu_1.i1.im[i] = prog_b[i];

        push(2, 0, K_PC,   0, 32'h00003000, "rerst_pc");
        push(2, 0, K_REG,  1, 32'h00000000, "rerst_r1");
        push(2, 0, K_REG,  3, 32'h00000000, "rerst_r3");
        push(2, 1, K_PC,   0, 32'h00003008, "beq_taken_pc");
        push(2, 2, K_PC,   0, 32'h00003010, "jal_pc");
        push(2, 2, K_REG, 31, 32'h0000300C, "jal_link");
        push(2, 3, K_PC,   0, 32'h0000300C, "jr_pc");
        push(2, 4, K_REG, 21, 32'h00000055, "after_jr_r21");
        push(2, 4, K_REG, 20, 32'h00000000, "beq_skipped_r20");
        push(2, 4, K_PC,   0, 32'h00003010, "after_jr_pc");

        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        drain_wait();

        checks++;
        if (dut.datapath_1.gpr_1.rgs[31] !== 32'h0000300C) begin
            errors++;
            $display("FAIL end_b_r31: actual %h, expected %h", dut.datapath_1.gpr_1.rgs[31], 32'h0000300C);
        end
        checks++;
        if (dut.datapath_1.gpr_1.rgs[21] !== 32'h00000055) begin
            errors++;
            $display("FAIL end_b_r21: actual %h, expected %h", dut.datapath_1.gpr_1.rgs[21], 32'h00000055);
        end
        checks++;
        if (dut.datapath_1.gpr_1.rgs[20] !== 32'h00000000) begin
            errors++;
            $display("FAIL end_b_r20: actual %h, expected %h", dut.datapath_1.gpr_1.rgs[20], 32'h00000000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
